// File: rtl/osd_trigger_pulser_if.sv
// osd_trigger_pulser_if: OSD trigger inputs, PLL lock and the pulse/reset outputs toward the core
interface osd_trigger_pulser_if #(
    parameter int NUM_TRIG = 4
);
    logic [NUM_TRIG-1:0] trig_in;
    logic                locked;
    logic [NUM_TRIG-1:0] pulse_out;
    logic [NUM_TRIG-1:0] busy;
    logic                rst_out_n;
    modport master (output trig_in, locked, input pulse_out, busy, rst_out_n);
    modport slave  (input trig_in, locked, output pulse_out, busy, rst_out_n);
endinterface

// File: rtl/osd_trigger_pulser.sv
// osd_trigger_pulser: OSD trigger bits to fixed-width pulses plus stretched core reset sequencing
module osd_trigger_pulser #(
    parameter int                  NUM_TRIG     = 4,
    parameter int                  PULSE_LEN    = 500000,
    parameter int                  CNT_W        = 20,
    parameter logic [NUM_TRIG-1:0] ACTIVE_LOW   = '0,
    parameter int                  RST_CH       = 3,
    parameter int                  RST_CNT_SIZE = 16
) (
    input logic                 clk_sys,
    input logic                 RESET,
    osd_trigger_pulser_if.slave io
);
    typedef enum logic [1:0] {HOLD, COUNT, RUN} state_t;
    localparam logic [CNT_W-1:0]        LOAD  = CNT_W'(PULSE_LEN - 1);
    localparam logic [RST_CNT_SIZE-1:0] RLAST = {{(RST_CNT_SIZE-1){1'b1}}, 1'b0};

    logic [NUM_TRIG-1:0] trig_s1, trig_s2, trig_s3, rise, busy, busy_nxt;
    logic [CNT_W-1:0]    cnt [NUM_TRIG];
    logic [CNT_W-1:0]    cnt_nxt [NUM_TRIG];
    logic                lock_s1, lock_s2, osd_rst, cause;
    logic [1:0]          fill;
    state_t              state, state_nxt;
    logic [RST_CNT_SIZE-1:0] rcnt, rcnt_nxt;

    // trig_s3 holds its all-ones reset value until the sync chain has refilled,
    // so triggers already high when RESET drops never look like a rise
    always_ff @(posedge clk_sys or posedge RESET)
        if (RESET) begin
            trig_s1 <= '0;
            trig_s2 <= '0;
            trig_s3 <= '1;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            fill    <= '0;
        end else begin
            trig_s1 <= io.trig_in;
            trig_s2 <= trig_s1;
            trig_s3 <= fill[1] ? trig_s2 : trig_s3;
            lock_s1 <= io.locked;
            lock_s2 <= lock_s1;
            fill    <= {fill[0], 1'b1};
        end

    always_comb begin
        rise = trig_s2 & ~trig_s3;
        for (int i = 0; i < NUM_TRIG; i++) begin
            busy_nxt[i] = rise[i] | (busy[i] & (cnt[i] != '0));
            cnt_nxt[i]  = rise[i] ? LOAD : (busy[i] && cnt[i] != '0) ? cnt[i] - 1'b1 : cnt[i];
        end
    end

    always_ff @(posedge clk_sys or posedge RESET)
        if (RESET) begin
            busy         <= '0;
            cnt          <= '{default: '0};
            io.pulse_out <= ACTIVE_LOW;
        end else begin
            busy         <= busy_nxt;
            cnt          <= cnt_nxt;
            io.pulse_out <= busy_nxt ^ ACTIVE_LOW;
        end

    assign io.busy = busy;

    // the reset channel is taken from next-state busy so rst_out_n drops on the pulse's first edge
    if (RST_CH < NUM_TRIG) begin : g_rst
        assign osd_rst = busy_nxt[RST_CH];
    end else begin : g_no_rst
        assign osd_rst = 1'b0;
    end

    assign cause = ~lock_s2 | osd_rst;

    always_comb begin
        state_nxt = cause ? HOLD : state == HOLD ? COUNT : (state == COUNT && rcnt == RLAST) ? RUN : state;
        rcnt_nxt  = (!cause && state == COUNT) ? rcnt + 1'b1 : '0;
    end

    always_ff @(posedge clk_sys or posedge RESET)
        if (RESET) begin
            state        <= HOLD;
            rcnt         <= '0;
            io.rst_out_n <= 1'b0;
        end else begin
            state        <= state_nxt;
            rcnt         <= rcnt_nxt;
            io.rst_out_n <= state_nxt == RUN;
        end
endmodule

// File: tb/tb_osd_trigger_pulser.sv
// tb_osd_trigger_pulser: directed scoreboard bench for the OSD trigger pulser
module tb_osd_trigger_pulser;
    localparam int        NT = 4;
    localparam logic [3:0] AL = 4'b0010;

    typedef struct {
        string      tag;
        logic [3:0] busy;
        logic       rst_n;
    } exp_t;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;
    exp_t q[$];
    exp_t e;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    osd_trigger_pulser_if #(.NUM_TRIG(NT)) io ();

    osd_trigger_pulser #(
        .NUM_TRIG(NT), .PULSE_LEN(4), .CNT_W(3), .ACTIVE_LOW(AL),
        .RST_CH(3), .RST_CNT_SIZE(3)
    ) dut (
        .clk_sys(clk_sys),
        .RESET  (RESET),
        .io     (io)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // drive inputs for the next edge and queue what the outputs must be right after it
    task automatic step(input string tag, input logic [3:0] trig, input logic lk,
                        input logic [3:0] eb, input logic er);
        io.trig_in = trig;
        io.locked  = lk;
        q.push_back('{tag, eb, er});
        @(negedge clk_sys);
    endtask

    always @(posedge clk_sys) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check({e.tag, " busy"}, io.busy, e.busy);
            check({e.tag, " pulse_out"}, io.pulse_out, e.busy ^ AL);
            check({e.tag, " rst_out_n"}, {3'b0, io.rst_out_n}, {3'b0, e.rst_n});
        end
    end

    initial begin
        io.trig_in = '0;
        io.locked  = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("reset busy", io.busy, 4'b0);
        check("reset pulse_out", io.pulse_out, AL);
        check("reset rst_out_n", {3'b0, io.rst_out_n}, 4'b0);
        RESET = 1'b0;
        for (int j = 0; j < 12; j++) step("bringup", 4'b0, 1'b1, 4'b0, j >= 9);
        for (int j = 0; j < 20; j++) step("single", 4'b0001, 1'b1, (j >= 2 && j < 6) ? 4'b0001 : 4'b0, 1'b1);
        for (int j = 0; j < 4; j++) step("single_fall", 4'b0, 1'b1, 4'b0, 1'b1);
        for (int j = 0; j < 12; j++)
            step("retrig", (j == 0 || j == 2) ? 4'b0010 : 4'b0, 1'b1, (j >= 2 && j < 8) ? 4'b0010 : 4'b0, 1'b1);
        for (int j = 0; j < 16; j++)
            step("osd_reset", j < 2 ? 4'b1000 : 4'b0, 1'b1, (j >= 2 && j < 6) ? 4'b1000 : 4'b0, j < 2 || j >= 13);
        for (int j = 0; j < 22; j++)
            step("lock_loss", j < 2 ? 4'b1000 : 4'b0, j != 9, (j >= 2 && j < 6) ? 4'b1000 : 4'b0, j < 2 || j >= 19);
        for (int j = 0; j < 4; j++) step("pre_abort", 4'b0100, 1'b1, j >= 2 ? 4'b0100 : 4'b0, 1'b1);
        RESET = 1'b1;
        #1;
        check("abort busy", io.busy, 4'b0);
        check("abort pulse_out", io.pulse_out, AL);
        check("abort rst_out_n", {3'b0, io.rst_out_n}, 4'b0);
        @(negedge clk_sys);
        RESET = 1'b0;
        for (int j = 0; j < 12; j++) step("after_abort", 4'b0100, 1'b1, 4'b0, j >= 9);
        for (int j = 0; j < 3; j++) step("rearm_low", 4'b0, 1'b1, 4'b0, 1'b1);
        for (int j = 0; j < 8; j++) step("rearm", 4'b0100, 1'b1, (j >= 2 && j < 6) ? 4'b0100 : 4'b0, 1'b1);
        @(negedge clk_sys);
        check("queue drained", 4'(q.size()), 4'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
